// File: rtl/ftdi_tx_axis_arbiter_pkg.sv
// Shared types and constants for the FT60x transmit arbiter (package ftdi_arb_pkg).
// Defining ARB_HDR_EN adds the HDR state used for the per-packet header beat.
package ftdi_arb_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header beat layout: {magic, source id, sequence} in tdata[31:0]
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_SEQ_W     = 16;
    localparam int HDR_ID_LSB    = 16;
    localparam int HDR_ID_W      = 8;
    localparam int HDR_MAGIC_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ARB_HDR_EN
        ST_HDR  = 2'd1,
`endif
        ST_XFER = 2'd2
    } arb_state_e;

    // Bits needed to index 'value' items; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ftdi_tx_axis_arbiter_if.sv
// AXI-Stream bundle with LANES parallel streams packed lane-by-lane.
// Handshake: a beat transfers on a clock edge where tvalid && tready; the master
// holds tdata/tkeep/tlast stable while tvalid is high and tready is low.
interface ftdi_tx_axis_arbiter_if #(
    parameter int LANES       = 1,
    parameter int TDATA_WIDTH = 4
);
    logic [LANES-1:0]               tvalid;
    logic [LANES-1:0]               tready;
    logic [LANES*TDATA_WIDTH*8-1:0] tdata;
    logic [LANES*TDATA_WIDTH-1:0]   tkeep;
    logic [LANES-1:0]               tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/ftdi_tx_axis_arbiter_rr_pick.sv
// Pure combinational round-robin picker: first request at or above last_ptr+1,
// wrapping around; also intended for reuse by the RX demux.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        int j;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        j          = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(last_ptr) + i;
            if (j >= N) j = j - N;
            if (!gnt_valid && j < N && req[j]) begin
                gnt_valid     = 1'b1;
                gnt_idx       = IW'(j);
                gnt_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_axis_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-S sources into the FT60x tx stream.
// Optional ARB_HDR_EN macro inserts a {A5, id, seq} header beat before each packet.
module ftdi_tx_axis_arbiter
    import ftdi_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_WIDTH = 4,
    parameter int MAX_BEATS   = 1024,
    localparam int GW         = clog2(NUM_SRC),
    localparam int CW         = clog2(MAX_BEATS),
    localparam int DW         = TDATA_WIDTH * 8
) (
    input  logic                  tx_clk,
    input  logic                  rst_glbl,
    input  logic [NUM_SRC-1:0]    ch_enable,
    ftdi_tx_axis_arbiter_if.slave  s_axis,
    ftdi_tx_axis_arbiter_if.master m_axis,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  err_oversize,
    output arb_state_e            state_dbg
);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         last_grant_q;
    logic [NUM_SRC-1:0]    grant_oh_q;
    logic [CW-1:0]         beat_cnt_q;

    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC-1:0]    pick_onehot;
    logic [GW-1:0]         pick_idx;
    logic                  pick_valid;

    logic                  m_hs;
    logic                  src_last;
    logic                  at_limit;
    logic                  end_beat;
    logic                  pkt_end;
    logic                  force_end;

`ifdef ARB_HDR_EN
    logic [HDR_SEQ_W-1:0]  seq_q [NUM_SRC];
`endif

    assign req = s_axis.tvalid & ch_enable;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (GW)
    ) u_pick (
        .req        (req),
        .last_ptr   (last_grant_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .gnt_valid  (pick_valid)
    );

    assign m_hs      = m_axis.tvalid & m_axis.tready;
    assign src_last  = s_axis.tlast[grant_id];
    // The beat with index MAX_BEATS-1 (header included) always closes the packet.
    assign at_limit  = (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign end_beat  = src_last | at_limit;
    assign pkt_end   = (state_q == ST_XFER) && m_hs && end_beat;
    assign force_end = pkt_end && !src_last;

    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d       = state_q;
        s_axis.tready = '0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
`ifdef ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
`endif
                end
            end
`ifdef ARB_HDR_EN
            ST_HDR: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata[HDR_MAGIC_LSB +: 8]      = HDR_MAGIC;
                m_axis.tdata[HDR_ID_LSB +: HDR_ID_W]  = HDR_ID_W'(grant_id);
                m_axis.tdata[HDR_SEQ_LSB +: HDR_SEQ_W] = seq_q[grant_id];
                m_axis.tkeep  = '1;
                if (m_axis.tready) state_d = ST_XFER;
            end
`endif
            ST_XFER: begin
                m_axis.tvalid = s_axis.tvalid[grant_id];
                m_axis.tdata  = s_axis.tdata[int'(grant_id)*DW +: DW];
                m_axis.tkeep  = s_axis.tkeep[int'(grant_id)*TDATA_WIDTH +: TDATA_WIDTH];
                m_axis.tlast  = end_beat;
                s_axis.tready = grant_oh_q & {NUM_SRC{m_axis.tready}};
                if (m_hs && end_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge rst_glbl) begin
        if (rst_glbl) begin
            state_q      <= ST_IDLE;
            grant_id     <= '0;
            grant_oh_q   <= '0;
            last_grant_q <= GW'(NUM_SRC - 1);
            beat_cnt_q   <= '0;
            err_oversize <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_oversize <= force_end;
            if (state_q == ST_IDLE && pick_valid) begin
                grant_id   <= pick_idx;
                grant_oh_q <= pick_onehot;
            end
            if (pkt_end) begin
                last_grant_q <= grant_id;
                beat_cnt_q   <= '0;
            end else if (m_hs) begin
                beat_cnt_q <= beat_cnt_q + CW'(1);
            end
        end
    end

`ifdef ARB_HDR_EN
    always_ff @(posedge tx_clk or posedge rst_glbl) begin
        if (rst_glbl) begin
            for (int k = 0; k < NUM_SRC; k++) seq_q[k] <= '0;
        end else if (pkt_end) begin
            seq_q[grant_id] <= seq_q[grant_id] + HDR_SEQ_W'(1);
        end
    end
`endif

endmodule

// File: doc/ftdi_tx_axis_arbiter.md
Name: ftdi_tx_axis_arbiter

Overview:
Packet-level round-robin arbiter that merges up to N user AXI-Stream sources into the single transmit stream of the FT60x 245-FIFO driver (its s_axis port). It runs in the driver's tx_clk domain and grants whole packets, so packets from different sources never interleave. It also guards against runaway packets by forcing termination after a configurable beat count.

Parameters:
NUM_SRC, 4, number of requesting sources (2-8)
TDATA_WIDTH, 4, data width in bytes on all streams (1-512; ≥4 if ARB_HDR_EN)
MAX_BEATS, 1024, maximum beats per output packet before forced tlast (2-65535)

Ports:
tx_clk  in  1  transmit clock, shared with FT60x driver tx_clk
rst_glbl  in  1  asynchronous active-high reset
ch_enable  in  NUM_SRC  per-source arbitration enable mask
s_axis_tvalid  in  NUM_SRC  source valid, one bit per source
s_axis_tready  out  NUM_SRC  source ready
s_axis_tdata  in  NUM_SRC*TDATA_WIDTH*8  source data, source k at slice k
s_axis_tkeep  in  NUM_SRC*TDATA_WIDTH  source byte keep
s_axis_tlast  in  NUM_SRC  source end of packet
m_axis_tvalid  out  1  to driver s_axis_tvalid
m_axis_tready  in  1  from driver s_axis_tready
m_axis_tdata  out  TDATA_WIDTH*8  merged data
m_axis_tkeep  out  TDATA_WIDTH  merged keep (driver tstrb tied to the same value outside this block)
m_axis_tlast  out  1  merged end of packet
grant_id  out  clog2(NUM_SRC)  currently/last granted source
busy  out  1  high while a packet is owned (state ≠ IDLE)
err_oversize  out  1  one-cycle pulse when a packet is force-terminated

Behaviour:
- Reset (async assert, sync-release assumed upstream): state=IDLE; all s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; tdata/tkeep=0; grant_id=0; last-grant pointer=NUM_SRC-1 (so source 0 wins first); beat counter=0; busy=0; err_oversize=0.
- FSM states: IDLE, (HDR if ARB_HDR_EN), XFER.
- IDLE: req = s_axis_tvalid & ch_enable. If req≠0, choose the first set bit searching upward from last_grant+1 with wrap-around; register grant_id and go to XFER (or HDR). Fixed 1-cycle arbitration bubble: m_axis_tvalid is first asserted the cycle after grant.
- XFER: combinational mux. m_axis_{tvalid,tdata,tkeep,tlast} = granted source; s_axis_tready[grant]=m_axis_tready; all other tready=0. Beat counter increments on each m handshake.
- Packet end: handshake with source tlast=1 → last_grant=grant_id, counter=0, go to IDLE. Back-to-back packets therefore always incur one bubble cycle.
- Forced end: on the handshake where counter==MAX_BEATS-1 and source tlast=0, drive m_axis_tlast=1, pulse err_oversize the following cycle, and go to IDLE. The remaining beats of that source are arbitrated as a new packet; round-robin fairness applies.
- ch_enable deasserted mid-packet: no effect until the packet ends; masks only new grants.
- Source drops tvalid mid-packet: grant is held and m_axis_tvalid follows; no timeout.
- m_axis_tready low: all sources are stalled and outputs are held stable (AXI-S rule).
- Reset mid-packet: immediate return to reset values; the partial packet is abandoned, and the driver FIFO is reset by the same rst_glbl.

Optional Feature:
ARB_HDR_EN — when defined, after a grant the FSM enters HDR and emits one header beat before the payload: tdata[31:0]={8'hA5, 8'(grant_id), 16'(per-source packet sequence)}, upper bytes 0, tkeep all-ones, tlast=0, and all source tready=0 during HDR. The sequence counter per source increments at each packet end (normal or forced) and wraps at 16'hFFFF→0. The header beat counts toward MAX_BEATS. When not defined: no HDR state, no sequence counters, payload only.

Decomposition:
- Shared package ftdi_arb_pkg: FSM state encoding, HDR_MAGIC=8'hA5, clog2 function, header field offsets.
- One sub-module, rr_pick: pure round-robin priority picker (req vector, last pointer → one-hot/index, valid). Reused by a future RX demux.

Test Plan:
- Single source 0, 3-beat packet, tready=1 → m_tvalid rises 1 cycle after s_tvalid; 3 beats emitted; tlast on beat 3; grant_id=0.
- Sources 0,1,2 all hold 2-beat packets continuously → output order 0,1,2,0,1,2; exactly one bubble between packets; no interleave.
- Source 1 valid, ch_enable[1]=0 while source 3 valid → source 3 granted; then enabling ch1 mid-packet of source 3 does not preempt.
- MAX_BEATS=4, source 2 sends 6 beats without tlast → output packet of 4 beats with forced tlast, err_oversize pulses once, remaining 2 beats follow as a new packet.
- m_axis_tready toggling 1/0 every cycle during a 5-beat packet → data stable while stalled; 5 beats delivered in order.
- ARB_HDR_EN: two packets from source 1 → headers 0xA5010000, then 0xA5010001; assert rst_glbl mid-packet → all outputs 0 next edge.
